minority_window_acc: RTL

//  Downstream consumer of the 3-input minority function (y=1 when >=2 of a,b,c are 0).

---
 rtl/minority_window_acc.sv | 91 +++++++++
 1 files changed

// File: rtl/minority_window_acc.sv
// Counts 3-input minority-true samples over a window of WINDOW accepted samples and
// presents the count and a threshold flag as a held valid/ready result.
module minority_window_acc #(
  parameter int WINDOW = 16,
  parameter int THRESH = 8,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_flag,
  output logic             dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // The producer holds valid and its data until that edge; ready never depends on valid.

  localparam int IDX_W = $clog2(WINDOW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW - 1);
  localparam logic [CNT_W:0]   THRESH_V = (CNT_W + 1)'(THRESH);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_acc;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_count;
  logic             r_flag;

  logic             w_y;
  logic             w_accept;
  logic [CNT_W:0]   w_sum;

  assign w_y      = (~a & ~b) | (~a & ~c) | (~b & ~c);
  assign w_accept = in_valid & in_ready;
  // One spare bit so the flag compare sees the full-window value without wrap
  assign w_sum    = {1'b0, r_acc} + {{CNT_W{1'b0}}, w_y};

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_HOLD);
  assign out_count = r_count;
  assign out_flag  = r_flag;
  assign dbg_state = r_state[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACCUM;
      r_acc   <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_flag  <= 1'b0;
    end else if (clr) begin
      r_state <= S_ACCUM;
      r_acc   <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            if (r_idx == IDX_LAST) begin
              r_count <= w_sum[CNT_W-1:0];
              r_flag  <= (w_sum >= THRESH_V);
              r_acc   <= '0;
              r_idx   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_acc <= w_sum[CNT_W-1:0];
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (out_ready) r_state <= S_ACCUM;
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

endmodule
